// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: command opcodes, FSM states and field widths shared by the
// pulse generator command sink and its top level.
package pulse_gen_pkg;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int VAL_W   = 28;
    localparam int BURST_W = 16;

    typedef enum logic [3:0] {
        OP_SET_PERIOD = 4'h1,
        OP_SET_HIGH   = 4'h2,
        OP_CTRL       = 4'h3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    typedef struct packed {
        op_e              op;
        logic [VAL_W-1:0] val;
    } cmd_t;

endpackage

// File: rtl/axi_if.sv
// axi_if: minimal AXI-stream bundle (tvalid/tready/tdata/tid) shared by the
// addressed components on the bus.
interface axi_if;

    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [7:0]  tid;

    modport master (output tvalid, output tdata, output tid, input tready);
    modport slave  (input tvalid, input tdata, input tid, output tready);

endinterface

// File: rtl/pulse_gen_cmd.sv
// pulse_gen_cmd: AXI-stream sink, tid filter, command legality check and the
// one-entry pending slot. cmd_err exists only with PULSE_GEN_STATUS_EN.
module pulse_gen_cmd
    import pulse_gen_pkg::*;
#(
    parameter logic [7:0] COMPONENT_ID = 8'h3E
) (
    input  logic             clk,
    input  logic             rst,
    axi_if.slave             axi,
    input  logic [VAL_W-1:0] period,
    input  logic             apply,
    output logic             pend_valid,
    output cmd_t             pend
`ifdef PULSE_GEN_STATUS_EN
    ,
    output logic             cmd_err
`endif
);

    logic             accept;
    logic             own;
    logic             legal;
    logic             load;
    logic             tready_q;
    logic [3:0]       op_raw;
    logic [VAL_W-1:0] val;

    assign accept = axi.tvalid && axi.tready;
    assign own    = (axi.tid == COMPONENT_ID);
    assign op_raw = axi.tdata[OP_MSB:OP_LSB];
    assign val    = axi.tdata[VAL_W-1:0];
    assign load   = accept && own && legal;

    // SET_HIGH is judged against the period active at accept time
    always_comb begin
        legal = 1'b0;
        unique case (op_raw)
            OP_SET_PERIOD: legal = (val >= VAL_W'(2));
            OP_SET_HIGH:   legal = (val != '0) && (val < period);
            OP_CTRL:       legal = 1'b1;
            default:       legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend       <= '0;
            tready_q   <= 1'b0;
        end else begin
            tready_q <= !pend_valid && !load;
            if (load) begin
                pend_valid <= 1'b1;
                pend.op    <= op_e'(op_raw);
                pend.val   <= val;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign axi.tready = tready_q;

`ifdef PULSE_GEN_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_err <= 1'b0;
        end else if (accept && own && !legal) begin
            cmd_err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse train (period, high time, burst) configured
// over AXI-stream. Optional sticky cmd_err via PULSE_GEN_STATUS_EN.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter logic [7:0]  COMPONENT_ID = 8'h3E,
    parameter int unsigned RST_PERIOD   = 100,
    parameter int unsigned RST_HIGH     = 50
) (
    input  logic clk,
    input  logic rst,
    axi_if.slave axi,
    output logic pulse_out,
    output logic running
`ifdef PULSE_GEN_STATUS_EN
    ,
    output logic cmd_err
`endif
);

    state_e             state;
    state_e             n_state;
    logic [VAL_W-1:0]   period;
    logic [VAL_W-1:0]   high;
    logic [VAL_W-1:0]   cnt;
    logic [VAL_W-1:0]   n_period;
    logic [VAL_W-1:0]   n_high;
    logic [VAL_W-1:0]   n_cnt;
    logic [VAL_W-1:0]   low_len;
    logic               enable;
    logic               n_enable;
    logic [BURST_W-1:0] burst;
    logic [BURST_W-1:0] bcnt;
    logic [BURST_W-1:0] n_burst;
    logic [BURST_W-1:0] n_bcnt;
    logic               pend_valid;
    logic               apply;
    logic               boundary;
    cmd_t               pend;

    pulse_gen_cmd #(
        .COMPONENT_ID(COMPONENT_ID)
    ) u_cmd (
        .clk       (clk),
        .rst       (rst),
        .axi       (axi),
        .period    (period),
        .apply     (apply),
        .pend_valid(pend_valid),
        .pend      (pend)
`ifdef PULSE_GEN_STATUS_EN
        ,
        .cmd_err   (cmd_err)
`endif
    );

    // Next active registers: burst accounting first, then a pending word
    always_comb begin
        n_period = period;
        n_high   = high;
        n_enable = enable;
        n_burst  = burst;
        n_bcnt   = bcnt;
        boundary = (state == ST_LOW) && (cnt == '0);
        apply    = pend_valid && ((state == ST_IDLE) || boundary);
        if (boundary) begin
            n_bcnt = bcnt + 1'b1;
            if ((burst != '0) && (n_bcnt == burst)) begin
                n_enable = 1'b0;
            end
        end
        if (apply) begin
            unique case (pend.op)
                OP_SET_PERIOD: n_period = pend.val;
                OP_SET_HIGH:   n_high   = pend.val;
                OP_CTRL: begin
                    n_enable = pend.val[0];
                    n_burst  = pend.val[BURST_W:1];
                    n_bcnt   = '0;
                end
                default: n_period = period;
            endcase
        end
    end

    // A period shortened below the high time still gets one LOW cycle
    always_comb begin
        low_len = (period > high) ? (period - high) : VAL_W'(1);
        n_state = state;
        n_cnt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (enable && !apply) begin
                    n_state = ST_HIGH;
                    n_cnt   = high - 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt == '0) begin
                    n_state = ST_LOW;
                    n_cnt   = low_len - 1'b1;
                end else begin
                    n_cnt = cnt - 1'b1;
                end
            end
            ST_LOW: begin
                if (cnt == '0) begin
                    if (n_enable) begin
                        n_state = ST_HIGH;
                        n_cnt   = n_high - 1'b1;
                    end else begin
                        n_state = ST_IDLE;
                    end
                end else begin
                    n_cnt = cnt - 1'b1;
                end
            end
            default: n_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            period    <= VAL_W'(RST_PERIOD);
            high      <= VAL_W'(RST_HIGH);
            cnt       <= '0;
            enable    <= 1'b0;
            burst     <= '0;
            bcnt      <= '0;
            pulse_out <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= n_state;
            period    <= n_period;
            high      <= n_high;
            cnt       <= n_cnt;
            enable    <= n_enable;
            burst     <= n_burst;
            bcnt      <= n_bcnt;
            pulse_out <= (n_state == ST_HIGH);
            running   <= (n_state != ST_IDLE);
        end
    end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Programmable pulse generator that is the output counterpart of the frequency counter: where the counter measures an incoming pulse train and streams results out over `axi_if`, this block receives configuration words over `axi_if` as a stream sink and synthesises a pulse train of commanded period, high time and burst length. It sits on the same AXI-stream bus as the other addressed components and selects its words by `COMPONENT_ID`.

## Interface
- `COMPONENT_ID`, 8'h3E: value of `tid` addressed to this block.
- `RST_PERIOD`, 100: period in clk cycles after reset; must be ≥ 2.
- `RST_HIGH`, 50: high time in clk cycles after reset; must be in 1..`RST_PERIOD`-1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `axi`  slave modport of `axi_if`  —  uses `tvalid`, `tready`, `tdata[31:0]`, `tid[7:0]`.
- `pulse_out`  out  1  generated pulse train, registered.
- `running`  out  1  high while the FSM is in HIGH or LOW.
- `cmd_err`  out  1  sticky illegal-command flag; present only with `PULSE_GEN_STATUS_EN`.

## Operation
- Command word: `tdata[31:28]` opcode, `tdata[27:0]` value.
  - 4'h1 SET_PERIOD: period = value.
  - 4'h2 SET_HIGH: high time = value.
  - 4'h3 CTRL: bit 0 = enable; bits 16:1 = burst count, 0 = continuous.
- Handshake: a word transfers on an edge with `tvalid && tready`. Words with `tid != COMPONENT_ID` are accepted and dropped.
- An accepted own word loads a one-entry pending slot and sets `pending_valid`. `tready = !pending_valid`, registered.
- Pending slot apply:
  - In IDLE: applied to the active registers on the next edge.
  - While running: applied only at the period boundary, i.e. the last LOW cycle. Periods are never truncated.
- Illegal words are dropped and never reach the active registers. Illegal means unknown opcode, SET_PERIOD < 2, SET_HIGH = 0, or SET_HIGH ≥ active period.
- FSM states and transitions:
  - IDLE, `pulse_out`=0: go to HIGH when enable=1 after apply.
  - HIGH, `pulse_out`=1: lasts `high` cycles, then go to LOW.
  - LOW, `pulse_out`=0: lasts `period-high` cycles. At the boundary, apply pending, then go to HIGH if enable=1, else IDLE.
- Burst: a 16-bit counter of emitted pulses. When it reaches a nonzero burst count at a boundary, enable clears and the FSM goes to IDLE.
- Writing CTRL reloads the burst counter to 0.
- Counters are 28-bit unsigned; `period-high` is computed from the active registers at the apply point.

## Timing
- Reset values: `pulse_out`=0, `running`=0, `tready`=0, `cmd_err`=0, FSM=IDLE, enable=0, period=`RST_PERIOD`, high=`RST_HIGH`, pending empty.
- `tready` rises on the first edge after `rst` deasserts.
- IDLE start: handshake on edge E0 → apply on E0+1 → `pulse_out` and `running` high after E0+2.
- While running, `tready` stays low from the accept edge until the boundary edge that applies the word. It goes high one edge later.
- Disable while running: the current period completes, then IDLE. `running` falls together with the final LOW→IDLE transition.
- Reset mid-pulse: `pulse_out` goes low asynchronously and all state returns to reset values.
- Accept and apply on the same edge cannot happen, because `tready` is low while the slot is full.

## Configuration
- `PULSE_GEN_STATUS_EN` defined:
  - `cmd_err` port exists.
  - `cmd_err` sets on the edge an illegal own word is accepted and clears only on reset.
- `PULSE_GEN_STATUS_EN` not defined:
  - Port and logic are absent.
  - Illegal words are silently dropped.

## Structure
- `pulse_gen_pkg`:
  - opcode enum (`OP_SET_PERIOD`, `OP_SET_HIGH`, `OP_CTRL`).
  - FSM state enum (`ST_IDLE`, `ST_HIGH`, `ST_LOW`).
  - field constants: `OP_MSB`/`OP_LSB`, `VAL_W`=28, `BURST_W`=16.
- Sub-module `pulse_gen_cmd`: AXI sink, `tid` filter, decode/legality check, and the pending slot with `tready` generation.
- Top `pulse_gen`: active registers, FSM, counters.

## Test plan
- Reset, then CTRL enable=1, continuous. Expected: `pulse_out` high 50 cycles and low 50 cycles, repeating; first rise 2 cycles after handshake.
- SET_PERIOD 10, SET_HIGH 3, CTRL enable with burst 4, all with `tvalid` held. Expected: `tready` low between accepts; exactly 4 pulses of 3 high / 7 low; then IDLE with `running`=0.
- SET_HIGH 20 sent mid-HIGH while running at period 100. Expected: current period stays 50/50; next period 20/80; `tready` low until that boundary.
- Word with `tid`=8'h7F. Expected: accepted with `tready` still high, no state change, `cmd_err` stays 0.
- SET_PERIOD 1, then SET_HIGH 200 at period 100, with the macro defined. Expected: both dropped, `cmd_err`=1, waveform unchanged; without the macro, same waveform.
- `rst` asserted mid-HIGH. Expected: `pulse_out`=0 immediately; after release, period=100, high=50, IDLE until a new enable.
